// File: rtl/tile_feeder.sv
// tile_feeder: skewed west/north edge driver for an NxN systolic tile, with EN gating, zero flush and DONE pulse.
module tile_feeder #(
  parameter int N = 8,
  parameter int W = 16,
  parameter int K = 8
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_start,
  output logic           o_busy,
  input  logic           i_in_valid,
  output logic           o_in_ready,
  input  logic [N*W-1:0] i_in_a,
  input  logic [N*W-1:0] i_in_b,
  output logic [N*W-1:0] o_a_edge,
  output logic [N*W-1:0] o_b_edge,
  output logic           o_tile_en,
  output logic           o_done
);
  localparam int BW = $clog2(K) + 1;
  localparam int FW = $clog2(2*N-2) + 1;
  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_FLUSH, S_FIN} state_t;
  state_t        r_state, w_next;
  logic [BW-1:0] r_beat;
  logic [FW-1:0] r_flush;
  logic          r_busy, r_ready, r_en, r_done;
  logic          w_stream, w_flush, w_adv, w_last_beat, w_last_flush;
  assign w_stream     = r_state == S_STREAM;
  assign w_flush      = r_state == S_FLUSH;
  assign w_adv        = (r_ready & i_in_valid) | w_flush;
  assign w_last_beat  = r_beat == BW'(K-1);
  assign w_last_flush = r_flush == FW'(2*N-3);
  always_comb begin
    w_next = r_state == S_IDLE   ? (i_start ? S_STREAM : S_IDLE)
           : r_state == S_STREAM ? ((i_in_valid && w_last_beat) ? S_FLUSH : S_STREAM)
           : r_state == S_FLUSH  ? (w_last_flush ? S_FIN : S_FLUSH)
           : S_IDLE;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_beat  <= '0;
      r_flush <= '0;
      r_busy  <= 1'b0;
      r_ready <= 1'b0;
      r_en    <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= w_next == S_STREAM || w_next == S_FLUSH;
      r_ready <= w_next == S_STREAM;
      r_en    <= w_adv;
      r_done  <= r_state == S_FIN;
      r_beat  <= r_state == S_IDLE ? '0 : (w_stream && i_in_valid && !w_last_beat) ? r_beat + 1'b1 : r_beat;
      r_flush <= !w_flush ? '0 : w_last_flush ? r_flush : r_flush + 1'b1;
    end
  end
  // lane i carries i+1 stages so the tile sees a diagonal wavefront
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [W-1:0] r_a [i+1];
    logic [W-1:0] r_b [i+1];
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        for (int s = 0; s <= i; s++) begin
          r_a[s] <= '0;
          r_b[s] <= '0;
        end
      end else if (w_adv) begin
        r_a[0] <= w_stream ? i_in_a[i*W +: W] : '0;
        r_b[0] <= w_stream ? i_in_b[i*W +: W] : '0;
        for (int s = 1; s <= i; s++) begin
          r_a[s] <= r_a[s-1];
          r_b[s] <= r_b[s-1];
        end
      end
    end
    assign o_a_edge[i*W +: W] = r_a[i];
    assign o_b_edge[i*W +: W] = r_b[i];
  end
  assign o_busy     = r_busy;
  assign o_in_ready = r_ready;
  assign o_tile_en  = r_en;
  assign o_done     = r_done;
endmodule
